// File: rtl/hx8352_init_seq_if.sv
// Write-beat channel from the init sequencer to the panel bus writer.
// A beat transfers on the cycle where wr_valid and wr_ready are both high.
interface hx8352_init_seq_if;
    logic       wr_valid;
    logic       wr_dc;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_dc, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_dc, input wr_data, output wr_ready);
endinterface

// File: rtl/hx8352_init_seq.sv
// HX8352 power-up sequencer: pulses the panel reset, then replays a {cmd,param} ROM as write beats.
// One ROM entry costs a FETCH and a DECODE cycle; beats hold steady while wr_ready is low.
module hx8352_init_seq #(
    parameter int unsigned CLKS_PER_MS = 50000,
    parameter int unsigned RST_LOW_MS  = 10,
    parameter int unsigned RST_WAIT_MS = 120
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [7:0]               rom_addr,
    input  logic [15:0]              rom_data,
    hx8352_init_seq_if.master        wr,
    output logic                     lcd_rst_n,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [31:0] RST_LOW_CYC  = 32'(RST_LOW_MS * CLKS_PER_MS);
    localparam logic [31:0] RST_WAIT_CYC = 32'(RST_WAIT_MS * CLKS_PER_MS);
    localparam logic [7:0]  CMD_END      = 8'hFF;
    localparam logic [7:0]  CMD_DELAY    = 8'hFE;

    typedef enum logic [3:0] {
        IDLE, RST_LOW, RST_WAIT, FETCH, DECODE, SEND_CMD, SEND_DATA, DELAY, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt, cnt_inc, dly_cycles;
    logic [7:0]  addr_nxt;
    logic [15:0] entry, entry_nxt;
    logic        err_nxt;
    logic        advance;
    logic [7:0]  rd_cmd, rd_param;

    assign rd_cmd     = rom_data[15:8];
    assign rd_param   = rom_data[7:0];
    assign cnt_inc    = cnt + 32'd1;
    assign dly_cycles = {24'd0, entry[7:0]} * CLKS_PER_MS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rom_addr <= '0;
            entry    <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rom_addr <= addr_nxt;
            entry    <= entry_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = rom_addr;
        entry_nxt = entry;
        err_nxt   = err;
        advance   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RST_LOW;
                    cnt_nxt   = '0;
                    addr_nxt  = '0;
                    err_nxt   = 1'b0;
                end
            end
            RST_LOW: begin
                if (cnt_inc >= RST_LOW_CYC) begin
                    state_nxt = RST_WAIT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            RST_WAIT: begin
                if (cnt_inc >= RST_WAIT_CYC) begin
                    state_nxt = FETCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            FETCH: state_nxt = DECODE;
            DECODE: begin
                entry_nxt = rom_data;
                cnt_nxt   = '0;
                if (rd_cmd == CMD_END) begin
                    state_nxt = DONE;
                end else if (rd_cmd == CMD_DELAY) begin
                    // A zero-length delay moves straight on without visiting DELAY.
                    if (rd_param == 8'd0) advance = 1'b1;
                    else                  state_nxt = DELAY;
                end else begin
                    state_nxt = SEND_CMD;
                end
            end
            SEND_CMD: begin
                if (wr.wr_ready) state_nxt = SEND_DATA;
            end
            SEND_DATA: begin
                if (wr.wr_ready) advance = 1'b1;
            end
            DELAY: begin
                if (cnt_inc >= dly_cycles) begin
                    advance = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The last ROM slot finishing without a terminator is a table error, never a wrap.
        if (advance) begin
            if (rom_addr == 8'hFF) begin
                state_nxt = DONE;
                err_nxt   = 1'b1;
            end else begin
                addr_nxt  = rom_addr + 8'd1;
                state_nxt = FETCH;
            end
        end
    end

    always_comb begin
        wr.wr_data = 8'd0;
        if (state == SEND_CMD)       wr.wr_data = entry[15:8];
        else if (state == SEND_DATA) wr.wr_data = entry[7:0];
    end

    assign wr.wr_valid = (state == SEND_CMD) || (state == SEND_DATA);
    assign wr.wr_dc    = (state == SEND_DATA);
    assign lcd_rst_n   = (state != RST_LOW);
    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_hx8352_init_seq.sv
// Directed bench for hx8352_init_seq with a 4-clk millisecond and a registered behavioural ROM.
module tb_hx8352_init_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        lcd_rst_n, busy, done, err;
    logic [15:0] rom [256];

    hx8352_init_seq_if wr ();

    hx8352_init_seq #(.CLKS_PER_MS(4), .RST_LOW_MS(1), .RST_WAIT_MS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .wr        (wr.master),
        .lcd_rst_n (lcd_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_vec = 0;
    int n_miss = 0;
    int low_cnt, wait_hi, first_valid, done_cyc, stall_cyc, stall_chg, addr12;
    int addr_cnt [256];
    logic [8:0]  beats [$];
    int          beat_cyc [$];
    logic [17:0] stall_ref;
    logic        stall_ref_set, rst_hit, err_c0;
    logic        snap_valid, snap_dc, snap_rstn, snap_busy, snap_done, snap_err;
    logic [7:0]  snap_data, snap_addr;
    logic [8:0]  exp_beats [6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_rom_a();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFF00;
        rom[0] = 16'h8302;
        rom[1] = 16'hFE0A;
        rom[2] = 16'hFE00;
        rom[3] = 16'h1122;
        rom[4] = 16'h2900;
        rom[5] = 16'hFF00;
    endtask

    task automatic load_rom_noterm();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0101;
    endtask

    // Pulses start, then samples each negedge; c=0 is the first RST_LOW cycle.
    task automatic run_seq(input int stall, input int pulse_at, input int rst_at, input int budget);
        int stall_left;
        logic [17:0] cur;
        low_cnt = 0; wait_hi = 0; first_valid = -1; done_cyc = -1;
        stall_cyc = 0; stall_chg = 0; addr12 = -1; stall_ref_set = 1'b0;
        rst_hit = 1'b0; err_c0 = 1'bx; stall_ref = '0;
        for (int i = 0; i < 256; i++) addr_cnt[i] = 0;
        beats.delete();
        beat_cyc.delete();
        stall_left = stall;
        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                snap_valid = wr.wr_valid; snap_dc = wr.wr_dc; snap_data = wr.wr_data;
                snap_addr = rom_addr; snap_rstn = lcd_rst_n; snap_busy = busy;
                snap_done = done; snap_err = err;
                rst_hit = 1'b1;
                break;
            end
            if (c == 0) err_c0 = err;
            if (c == 12) addr12 = rom_addr;
            if (!lcd_rst_n) low_cnt++;
            if (wr.wr_valid && first_valid < 0) first_valid = c;
            if (lcd_rst_n && busy && first_valid < 0) wait_hi++;
            if (busy) addr_cnt[rom_addr]++;
            cur = {wr.wr_valid, wr.wr_dc, wr.wr_data, rom_addr};
            if (wr.wr_valid && stall_left > 0) begin
                wr.wr_ready = 1'b0;
                stall_left--;
                stall_cyc++;
                if (!stall_ref_set) begin
                    stall_ref = cur;
                    stall_ref_set = 1'b1;
                end else if (cur != stall_ref) begin
                    stall_chg++;
                end
            end else begin
                wr.wr_ready = 1'b1;
            end
            if (wr.wr_valid && wr.wr_ready) begin
                beats.push_back({wr.wr_dc, wr.wr_data});
                beat_cyc.push_back(c);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        wr.wr_ready = 1'b0;
    endtask

    task automatic check_rom_a_beats(input string pfx);
        chk({pfx, "_nbeats"}, beats.size(), 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_beat%0d", pfx, i), (i < beats.size()) ? beats[i] : 9'h1FF, exp_beats[i]);
    endtask

    initial begin
        exp_beats[0] = 9'h083; exp_beats[1] = 9'h102; exp_beats[2] = 9'h011;
        exp_beats[3] = 9'h122; exp_beats[4] = 9'h029; exp_beats[5] = 9'h100;
        wr.wr_ready = 1'b0;
        load_rom_a();
        repeat (2) @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_wr_valid", wr.wr_valid, 0);
        chk("rst_wr_dc", wr.wr_dc, 0);
        chk("rst_wr_data", wr.wr_data, 0);
        chk("rst_lcd_rst_n", lcd_rst_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_lcd_rst_n", lcd_rst_n, 1);

        // Full table with a 5-cycle stall on the first command beat.
        run_seq(5, -1, -1, 300);
        chk("a_rst_low_cycles", low_cnt, 4);
        chk("a_rst_wait_plus_fetch", wait_hi, 10);
        chk("a_first_fetch_addr", addr12, 0);
        chk("a_first_valid_cycle", first_valid, 14);
        chk("a_stall_cycles", stall_cyc, 5);
        chk("a_stall_changes", stall_chg, 0);
        check_rom_a_beats("a");
        chk("a_cmd_accept_cycle", (beat_cyc.size() > 1) ? beat_cyc[0] : -1, 19);
        chk("a_data_accept_cycle", (beat_cyc.size() > 1) ? beat_cyc[1] : -1, 20);
        chk("a_delay10_addr_cycles", addr_cnt[1], 42);
        chk("a_delay0_addr_cycles", addr_cnt[2], 2);
        chk("a_cmd_addr_cycles", addr_cnt[3], 4);
        chk("a_done_cycle", done_cyc, 75);
        chk("a_done_busy", busy, 0);
        chk("a_done_lcd_rst_n", lcd_rst_n, 1);
        chk("a_done_err", err, 0);
        chk("a_done_wr_valid", wr.wr_valid, 0);
        repeat (10) @(negedge clk);
        chk("a_hold_done", done, 1);
        chk("a_hold_rom_addr", rom_addr, 5);

        // Restart from DONE; a start pulse mid-DELAY must be ignored.
        run_seq(5, 30, -1, 300);
        check_rom_a_beats("b");
        chk("b_done_cycle", done_cyc, 75);
        chk("b_done", done, 1);

        run_seq(5, -1, 30, 300);
        chk("rd_hit", rst_hit, 1);
        chk("rd_rom_addr", snap_addr, 0);
        chk("rd_busy", snap_busy, 0);
        chk("rd_lcd_rst_n", snap_rstn, 1);
        chk("rd_wr_valid", snap_valid, 0);
        chk("rd_done", snap_done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rd_after_busy", busy, 0);

        run_seq(5, -1, 68, 300);
        chk("rs_wr_valid", snap_valid, 0);
        chk("rs_wr_dc", snap_dc, 0);
        chk("rs_wr_data", snap_data, 0);
        chk("rs_rom_addr", snap_addr, 0);
        chk("rs_err", snap_err, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table with no terminator runs off the end of the ROM.
        load_rom_noterm();
        run_seq(0, -1, -1, 1200);
        chk("e_done_cycle", done_cyc, 1036);
        chk("e_err", err, 1);
        chk("e_done", done, 1);
        chk("e_rom_addr", rom_addr, 255);
        chk("e_nbeats", beats.size(), 512);
        chk("e_busy", busy, 0);

        load_rom_a();
        run_seq(0, -1, -1, 300);
        chk("f_err_cleared", err_c0, 0);
        chk("f_done_cycle", done_cyc, 70);
        chk("f_err", err, 0);
        check_rom_a_beats("f");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
